// File: rtl/iecdrv_pkg.sv
// Shared constants for the C1541 drive hub: drive count limits, ROM geometry
// and the arbiter slot map used by c1541_rom_arbiter.
package iecdrv_pkg;

  localparam int NDR_MAX   = 4;
  localparam int ROM_AW    = 15;
  localparam int ROM_DEPTH = 1 << ROM_AW;

  // Arbiter slots: address issue in 0..ADDR_LAST, data capture in
  // DATA_FIRST..DATA_LAST, then park in ARB_IDLE until the next ph2 fall.
  localparam logic [2:0] ARB_IDLE   = 3'd7;
  localparam logic [2:0] ADDR_LAST  = 3'd3;
  localparam logic [2:0] DATA_FIRST = 3'd3;
  localparam logic [2:0] DATA_LAST  = 3'd6;

  // Legal drive count is 1..NDR_MAX; anything else is pulled into range.
  function automatic int clamp_ndr(input int n);
    if (n < 1)       return 1;
    if (n > NDR_MAX) return NDR_MAX;
    return n;
  endfunction

endpackage

// File: rtl/iecdrv_sync.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable
// value loaded while the block is in reset.
module iecdrv_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q, s2_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/c1541_rom_arbiter.sv
// Shared hub for 1..4 C1541 drive cores: ph2 strobe generation, one shared
// drive ROM time-multiplexed across drives each ph2 cycle, ROM size
// detection, and wired-AND combining of IEC and parallel-port outputs.
// Optional feature macro: IECDRV_PARPORT_EN (32K ROM view + parallel port).
module c1541_rom_arbiter
  import iecdrv_pkg::*;
#(
  parameter int NDR = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              pause,
  input  logic [NDR-1:0]    drv_reset,
  input  logic              iec_atn_i,
  input  logic              iec_clk_i,
  input  logic              iec_data_i,
  output logic              iec_atn,
  output logic              iec_clk_fb,
  output logic              iec_data_fb,
  output logic              iec_clk_o,
  output logic              iec_data_o,
  input  logic [NDR-1:0]    iec_clk_d,
  input  logic [NDR-1:0]    iec_data_d,
  output logic              ph2_r,
  output logic              ph2_f,
  input  logic [15*NDR-1:0] drv_addr,
  output logic [8*NDR-1:0]  drv_data,
  input  logic [14:0]       rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_wr,
  input  logic              rom_std,
  input  logic [NDR-1:0]    led_drv,
  output logic [NDR-1:0]    led,
  input  logic [8*NDR-1:0]  par_data_d,
  input  logic [NDR-1:0]    par_stb_d,
  output logic [7:0]        par_data_o,
  output logic              par_stb_o,
  output logic [NDR-1:0]    ext_en
);

  localparam int ND = clamp_ndr(NDR);

  // ---------------- synchronisers ----------------
  logic           atn_s, clk_s, data_s;
  logic [NDR-1:0] drs;

  iecdrv_sync #(.W(3), .RST_VAL(3'b111)) u_sync_iec (
    .clk   (clk),
    .reset (reset),
    .d_i   ({iec_atn_i, iec_clk_i, iec_data_i}),
    .q_o   ({atn_s, clk_s, data_s})
  );

  iecdrv_sync #(.W(NDR), .RST_VAL({NDR{1'b1}})) u_sync_drs (
    .clk   (clk),
    .reset (reset),
    .d_i   (drv_reset),
    .q_o   (drs)
  );

  // ---------------- ph2 strobes ----------------
  logic [3:0] div_q;
  logic       ena1_q, ena_q, ph2_r_q, ph2_f_q;

  // Divide ce by 16; pause only takes effect at a ph2 phase boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      ena1_q  <= 1'b0;
      ena_q   <= 1'b0;
      ph2_r_q <= 1'b0;
      ph2_f_q <= 1'b0;
    end else begin
      ena1_q <= ~pause;
      if (div_q[2:0] != 3'd0) ena_q <= ena1_q;
      if (ce) begin
        div_q   <= div_q + 4'd1;
        ph2_r_q <= ena_q & ~div_q[3] & (div_q[2:0] == 3'd0);
        ph2_f_q <= ena_q &  div_q[3] & (div_q[2:0] == 3'd0);
      end else begin
        ph2_r_q <= 1'b0;
        ph2_f_q <= 1'b0;
      end
    end
  end

  assign ph2_r = ph2_r_q;
  assign ph2_f = ph2_f_q;

  // ---------------- ROM size detection ----------------
  logic       r32_q, r16_q, empty8k_q;
  logic [1:0] rom_sz_q;

  // Highest 8K bank holding real data decides the size; a write at 0
  // restarts the "lower 8K empty" detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r32_q     <= 1'b1;
      r16_q     <= 1'b1;
      empty8k_q <= 1'b1;
      rom_sz_q  <= 2'b11;
    end else begin
      if (rom_wr) begin
        if (rom_addr == 15'd0) empty8k_q <= 1'b1;
        if (rom_data != 8'h00 && rom_data != 8'hFF) begin
          {r32_q, r16_q} <= rom_addr[14:13];
          if (rom_addr[14:8] != 7'd0 && rom_addr[14:13] == 2'b00) empty8k_q <= 1'b0;
        end
      end
      rom_sz_q <= {r32_q, r32_q | r16_q};
    end
  end

  // ---------------- shared ROM ----------------
  logic [7:0]        rom_mem [ROM_DEPTH];
  logic [ROM_AW-1:0] mem_a_q, rom_ra_q;
  logic [7:0]        rom_q;

  // Loader write port; contents survive block reset.
  always_ff @(posedge clk) begin
    if (rom_wr) rom_mem[rom_addr] <= rom_data;
  end

  // Read port: registered address, registered data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_ra_q <= '0;
      rom_q    <= '0;
    end else begin
      rom_ra_q <= mem_a_q;
      rom_q    <= rom_mem[rom_ra_q];
    end
  end

  // ---------------- arbiter FSM ----------------
  logic [2:0] state_q, state_d;
  logic       addr_en, data_en;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Restart on every ph2 fall, otherwise count up and park at idle.
  always_comb begin
    state_d = state_q;
    if (ph2_f_q)                  state_d = 3'd0;
    else if (state_q != ARB_IDLE) state_d = state_q + 3'd1;
  end

  // Slot decode.
  always_comb begin
    addr_en = (state_q <= ADDR_LAST);
    data_en = (state_q >= DATA_FIRST) && (state_q <= DATA_LAST);
  end

  logic [14:0] sel_a;
  logic        addr_hit;
  logic        a14_m, a13_m;

  // Pick the address of the drive owning this slot.
  always_comb begin
    sel_a    = '0;
    addr_hit = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (addr_en && state_q == i[2:0]) begin
        sel_a    = drv_addr[15*i +: 15];
        addr_hit = 1'b1;
      end
    end
  end

`ifdef IECDRV_PARPORT_EN
  assign a14_m = sel_a[14] & rom_sz_q[1] & ~rom_std;
`else
  assign a14_m = 1'b0;
`endif
  assign a13_m = sel_a[13] & (rom_sz_q[0] | rom_std);

  logic [NDR-1:0][7:0] drv_data_q;

  // Issue drive addresses, then capture ROM data three slots later.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_a_q    <= '0;
      drv_data_q <= '0;
    end else begin
      if (addr_hit) mem_a_q <= {a14_m, a13_m, sel_a[12:0]};
      for (int i = 0; i < ND; i++) begin
        if (data_en && state_q == DATA_FIRST + i[2:0]) drv_data_q[i] <= rom_q;
      end
    end
  end

  assign drv_data = drv_data_q;

  // ---------------- IEC / LEDs ----------------
  // Drives held in reset release the bus (open-collector style AND).
  assign iec_clk_o   = &(iec_clk_d  | drs);
  assign iec_data_o  = &(iec_data_d | drs);
  assign iec_atn     = atn_s;
  assign iec_clk_fb  = clk_s  & iec_clk_o;
  assign iec_data_fb = data_s & iec_data_o;
  assign led         = led_drv & ~drs;

  // ---------------- parallel port ----------------
`ifdef IECDRV_PARPORT_EN
  // Expansion is live only with a 32K ROM whose lower 8K is empty.
  always_comb begin
    for (int i = 0; i < NDR; i++) begin
      ext_en[i] = rom_sz_q[1] & empty8k_q & ~rom_std & ~drs[i];
    end
  end

  assign par_stb_o = &(par_stb_d | ~ext_en);

  // AND of enabled drives' data; idle bus reads all ones.
  always_comb begin
    par_data_o = 8'hFF;
    for (int i = 0; i < NDR; i++) begin
      if (ext_en[i]) par_data_o = par_data_o & par_data_d[8*i +: 8];
    end
  end
`else
  assign ext_en     = '0;
  assign par_stb_o  = 1'b1;
  assign par_data_o = 8'hFF;

  logic unused_par;
  assign unused_par = &{1'b0, par_data_d, par_stb_d, sel_a[14], rom_sz_q[1], empty8k_q};
`endif

endmodule

// File: tb/tb_c1541_rom_arbiter.sv
// Bench for c1541_rom_arbiter (NDR=2). Honours IECDRV_PARPORT_EN when defined.
module tb_c1541_rom_arbiter;

  localparam int NDR = 2;
`ifdef IECDRV_PARPORT_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, ce, pause;
  logic [NDR-1:0]    drv_reset;
  logic              iec_atn_i, iec_clk_i, iec_data_i;
  logic              iec_atn, iec_clk_fb, iec_data_fb, iec_clk_o, iec_data_o;
  logic [NDR-1:0]    iec_clk_d, iec_data_d;
  logic              ph2_r, ph2_f;
  logic [15*NDR-1:0] drv_addr;
  logic [8*NDR-1:0]  drv_data;
  logic [14:0]       rom_addr;
  logic [7:0]        rom_data;
  logic              rom_wr, rom_std;
  logic [NDR-1:0]    led_drv, led;
  logic [8*NDR-1:0]  par_data_d;
  logic [NDR-1:0]    par_stb_d;
  logic [7:0]        par_data_o;
  logic              par_stb_o;
  logic [NDR-1:0]    ext_en;

  c1541_rom_arbiter #(.NDR(NDR)) dut (
    .clk(clk), .reset(reset), .ce(ce), .pause(pause), .drv_reset(drv_reset),
    .iec_atn_i(iec_atn_i), .iec_clk_i(iec_clk_i), .iec_data_i(iec_data_i),
    .iec_atn(iec_atn), .iec_clk_fb(iec_clk_fb), .iec_data_fb(iec_data_fb),
    .iec_clk_o(iec_clk_o), .iec_data_o(iec_data_o),
    .iec_clk_d(iec_clk_d), .iec_data_d(iec_data_d),
    .ph2_r(ph2_r), .ph2_f(ph2_f), .drv_addr(drv_addr), .drv_data(drv_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_wr(rom_wr), .rom_std(rom_std),
    .led_drv(led_drv), .led(led), .par_data_d(par_data_d), .par_stb_d(par_stb_d),
    .par_data_o(par_data_o), .par_stb_o(par_stb_o), .ext_en(ext_en)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: ROM image plus the size-detection flags.
  logic [7:0] mrom [32768];
  logic       m_r32, m_r16, m_e8;

  function automatic logic [1:0] m_sz();
    return {m_r32, m_r32 | m_r16};
  endfunction

  function automatic logic [14:0] m_map(input logic [14:0] a, input logic std);
    logic [1:0] sz;
    logic       b14, b13;
    sz  = m_sz();
    b14 = PP ? (a[14] & sz[1] & ~std) : 1'b0;
    b13 = a[13] & (sz[0] | std);
    return {b14, b13, a[12:0]};
  endfunction

  function automatic logic [7:0] m_read(input logic [14:0] a, input logic std);
    return mrom[m_map(a, std)];
  endfunction

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37) ^ (a >> 7) ^ 8'h5C);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_r32 = 1'b1; m_r16 = 1'b1; m_e8 = 1'b1;
  endtask

  task automatic rom_write(input logic [14:0] a, input logic [7:0] d);
    rom_addr = a; rom_data = d; rom_wr = 1'b1;
    @(negedge clk);
    rom_wr = 1'b0;
    mrom[a] = d;
    if (a == 15'd0) m_e8 = 1'b1;
    if (d != 8'h00 && d != 8'hFF) begin
      m_r32 = a[14]; m_r16 = a[13];
      if (a[14:8] != 7'd0 && a[14:13] == 2'b00) m_e8 = 1'b0;
    end
  endtask

  // Returns at the negedge where ph2_f is seen high; an expired bound is a failure.
  task automatic wait_ph2_f();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ph2_f) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_ph2_f: got no strobe within 40 clk, required one");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ph2_r, ph2_f} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {ph2_r, ph2_f}); end
    total++;
    if (drv_data !== '0) begin bad++; $display("FAIL reset_drv_data: got %h want 0", drv_data); end
    total++;
    if ({iec_atn, iec_clk_o, iec_data_o} !== 3'b111) begin bad++; $display("FAIL reset_iec: got %b want 111", {iec_atn, iec_clk_o, iec_data_o}); end
    total++;
    if (led !== '0) begin bad++; $display("FAIL reset_led: got %b want 00", led); end
    total++;
    if (ext_en !== '0) begin bad++; $display("FAIL reset_ext_en: got %b want 00", ext_en); end
    reset = 1'b0;
    m_r32 = 1'b1; m_r16 = 1'b1; m_e8 = 1'b1;
  endtask

  task automatic test_ph2();
    int rs[$];
    int fs[$];
    do_reset();
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (ph2_r) rs.push_back(c);
      if (ph2_f) fs.push_back(c);
    end
    total++;
    if (fs.size() != 4 || rs.size() != 4) begin bad++; $display("FAIL ph2_count: got r=%0d f=%0d want 4/4", rs.size(), fs.size()); end
    else begin
      total++;
      if (fs[0] != 9) begin bad++; $display("FAIL ph2_first_f: got %0d want 9", fs[0]); end
      total++;
      if (rs[0] != 17) begin bad++; $display("FAIL ph2_first_r: got %0d want 17", rs[0]); end
      for (int k = 1; k < 4; k++) begin
        total++;
        if (rs[k] - rs[k-1] != 16 || fs[k] - fs[k-1] != 16) begin
          bad++; $display("FAIL ph2_period: got r=%0d f=%0d want 16", rs[k] - rs[k-1], fs[k] - fs[k-1]);
        end
      end
    end
  endtask

  task automatic test_pause();
    int n;
    pause = 1'b1;
    repeat (40) @(negedge clk);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ph2_r || ph2_f) n++;
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL pause_quiet: got %0d strobes want 0", n); end
    pause = 1'b0;
    wait_ph2_f();
  endtask

  task automatic test_std_read();
    for (int a = 0; a < 16384; a++) rom_write(15'(a), 8'h5A);
    rom_std = 1'b1;
    drv_addr[0 +: 15]  = 15'h0040;
    drv_addr[15 +: 15] = 15'h0123;
    wait_ph2_f();
    wait_ph2_f();
    repeat (6) @(negedge clk);
    total++;
    if (drv_data[15:8] !== m_read(15'h0123, 1'b1)) begin
      bad++; $display("FAIL std_read_drv1: got %h want %h", drv_data[15:8], m_read(15'h0123, 1'b1));
    end
  endtask

  task automatic test_rom_size();
    logic [7:0] e0, e1;
    rom_write(15'h7FFF, 8'h11);
    rom_std = 1'b0;
    drv_addr[0 +: 15]  = 15'h6000;
    drv_addr[15 +: 15] = 15'h7FFF;
    wait_ph2_f();
    repeat (8) @(negedge clk);
    e0 = m_read(15'h6000, 1'b0); e1 = m_read(15'h7FFF, 1'b0);
    total++;
    if (drv_data !== {e1, e0}) begin bad++; $display("FAIL size32_read: got %h want %h", drv_data, {e1, e0}); end
    rom_write(15'h2100, 8'h22);
    drv_addr[15 +: 15] = 15'h2100;
    wait_ph2_f();
    repeat (8) @(negedge clk);
    total++;
    if (drv_data[7:0] !== mrom[15'h2000]) begin bad++; $display("FAIL size16_a14_mask: got %h want %h", drv_data[7:0], mrom[15'h2000]); end
    total++;
    if (drv_data[15:8] !== 8'h22) begin bad++; $display("FAIL size16_read: got %h want 22", drv_data[15:8]); end
  endtask

  task automatic test_random_reads();
    logic [14:0] a0, a1;
    logic        std;
    for (int k = 0; k < 6; k++) rom_write(15'($urandom_range(0, 32767)), 8'($urandom));
    for (int k = 0; k < 24; k++) begin
      a0 = 15'($urandom); a1 = 15'($urandom); std = 1'($urandom);
      if (k == 12) rom_write(15'h7FFF, 8'h33);
      drv_addr = {a1, a0}; rom_std = std;
      wait_ph2_f();
      repeat (5) @(negedge clk);
      total++;
      if (drv_data[7:0] !== m_read(a0, std)) begin bad++; $display("FAIL rand_drv0: a=%h got %h want %h", a0, drv_data[7:0], m_read(a0, std)); end
      @(negedge clk);
      total++;
      if (drv_data[15:8] !== m_read(a1, std)) begin bad++; $display("FAIL rand_drv1: a=%h got %h want %h", a1, drv_data[15:8], m_read(a1, std)); end
    end
  endtask

  task automatic test_iec();
    logic       eco, edo;
    logic [1:0] een;
    logic [1:0] sz;
    logic [7:0] epd;
    drv_reset = 2'b01; iec_clk_d = 2'b10; iec_clk_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (iec_clk_o !== 1'b1) begin bad++; $display("FAIL iec_reset_release: got %b want 1", iec_clk_o); end
    drv_reset = 2'b00;
    @(negedge clk);
    total++;
    if (iec_clk_o !== 1'b1) begin bad++; $display("FAIL iec_sync_1clk: got %b want 1", iec_clk_o); end
    @(negedge clk);
    total++;
    if (iec_clk_o !== 1'b0) begin bad++; $display("FAIL iec_sync_2clk: got %b want 0", iec_clk_o); end
    for (int k = 0; k < 20; k++) begin
      drv_reset = 2'($urandom); iec_clk_d = 2'($urandom); iec_data_d = 2'($urandom);
      {iec_atn_i, iec_clk_i, iec_data_i} = 3'($urandom);
      led_drv = 2'($urandom); par_data_d = 16'($urandom); par_stb_d = 2'($urandom);
      rom_std = 1'($urandom);
      repeat (3) @(negedge clk);
      eco = 1'b1; edo = 1'b1;
      for (int i = 0; i < NDR; i++) begin
        if (!drv_reset[i] && !iec_clk_d[i])  eco = 1'b0;
        if (!drv_reset[i] && !iec_data_d[i]) edo = 1'b0;
      end
      total++;
      if ({iec_clk_o, iec_data_o} !== {eco, edo}) begin bad++; $display("FAIL iec_and: got %b want %b", {iec_clk_o, iec_data_o}, {eco, edo}); end
      total++;
      if ({iec_atn, iec_clk_fb, iec_data_fb} !== {iec_atn_i, iec_clk_i & eco, iec_data_i & edo}) begin
        bad++; $display("FAIL iec_fb: got %b want %b", {iec_atn, iec_clk_fb, iec_data_fb}, {iec_atn_i, iec_clk_i & eco, iec_data_i & edo});
      end
      total++;
      if (led !== (led_drv & ~drv_reset)) begin bad++; $display("FAIL led_mask: got %b want %b", led, led_drv & ~drv_reset); end
      sz = m_sz();
      een = '0; epd = 8'hFF;
      for (int i = 0; i < NDR; i++) begin
        een[i] = PP & sz[1] & m_e8 & ~rom_std & ~drv_reset[i];
        if (een[i]) epd = epd & par_data_d[8*i +: 8];
      end
      total++;
      if (ext_en !== een) begin bad++; $display("FAIL ext_en: got %b want %b", ext_en, een); end
      total++;
      if ({par_data_o, par_stb_o} !== {epd, &(par_stb_d | ~een)}) begin
        bad++; $display("FAIL par_combine: got %h/%b want %h/%b", par_data_o, par_stb_o, epd, &(par_stb_d | ~een));
      end
    end
  endtask

  task automatic test_parport();
    logic [7:0] want;
    drv_reset = 2'b00;
    rom_write(15'h0000, 8'h11);
    rom_write(15'h7FFF, 8'h11);
    rom_std = 1'b0; par_data_d = {8'h3C, 8'hF0}; par_stb_d = 2'b01;
    repeat (3) @(negedge clk);
    want = PP ? 8'h30 : 8'hFF;
    total++;
    if (par_data_o !== want) begin bad++; $display("FAIL par_data_32k: got %h want %h", par_data_o, want); end
    total++;
    if (par_stb_o !== (PP ? 1'b0 : 1'b1)) begin bad++; $display("FAIL par_stb_32k: got %b want %b", par_stb_o, ~PP); end
    rom_std = 1'b1;
    @(negedge clk);
    total++;
    if ({par_data_o, par_stb_o, ext_en} !== {8'hFF, 1'b1, 2'b00}) begin
      bad++; $display("FAIL par_std_off: got %h/%b/%b want ff/1/00", par_data_o, par_stb_o, ext_en);
    end
  endtask

  task automatic test_mid_reset();
    logic [14:0] a0, a1;
    a0 = 15'h1234; a1 = 15'h5678;
    drv_addr = {a1, a0}; rom_std = 1'b0;
    wait_ph2_f();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({ph2_r, ph2_f} !== 2'b00 || drv_data !== '0) begin
      bad++; $display("FAIL mid_reset: got strobes=%b data=%h want 00/0", {ph2_r, ph2_f}, drv_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_r32 = 1'b1; m_r16 = 1'b1; m_e8 = 1'b1;
    wait_ph2_f();
    repeat (8) @(negedge clk);
    total++;
    if (drv_data !== {m_read(a1, 1'b0), m_read(a0, 1'b0)}) begin
      bad++; $display("FAIL rom_kept: got %h want %h", drv_data, {m_read(a1, 1'b0), m_read(a0, 1'b0)});
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; pause = 1'b0; drv_reset = '0;
    iec_atn_i = 1'b1; iec_clk_i = 1'b1; iec_data_i = 1'b1;
    iec_clk_d = '1; iec_data_d = '1; drv_addr = '0;
    rom_addr = '0; rom_data = '0; rom_wr = 1'b0; rom_std = 1'b0;
    led_drv = '1; par_data_d = '1; par_stb_d = '1;
    m_r32 = 1'b1; m_r16 = 1'b1; m_e8 = 1'b1;

    test_reset();
    test_ph2();
    for (int a = 0; a < 32768; a++) rom_write(15'(a), pat(a));
    test_std_read();
    test_rom_size();
    test_random_reads();
    test_iec();
    test_parport();
    test_pause();
    test_mid_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
